// File: rtl/riscv_ctrl_pkg.sv
// Shared control encodings for the RV32I cores: opcodes, FSM states and
// datapath mux codes used by the multicycle controller and its decoders.
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10,
        S_TRAP     = 4'd11
    } state_e;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

endpackage

// File: rtl/imm_src_decode.sv
// Opcode to immediate-format decode; purely combinational so both the
// single-cycle and multicycle cores can share it.
module imm_src_decode
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0] op,
    output logic [1:0] imm_src
);

    always_comb begin
        imm_src = IMM_I;
        case (op)
            OP_SW:   imm_src = IMM_S;
            OP_BEQ:  imm_src = IMM_B;
            OP_JAL:  imm_src = IMM_J;
            default: imm_src = IMM_I;
        endcase
    end

endmodule

// File: rtl/multicycle_main_fsm.sv
// Main control FSM of the multicycle RV32I core, with memory-wait timeout,
// illegal-opcode trap and retired-instruction counter.
//
//   state    | meaning
//   FETCH    | read instruction at PC, PC <= PC+4 on mem_ready
//   DECODE   | read registers, precompute branch target OldPC+imm
//   MEMADR   | rs1 + imm for lw/sw
//   MEMREAD  | data read at ALUOut
//   MEMWB    | write loaded data to rd, retire
//   MEMWRITE | data write at ALUOut, retire on mem_ready
//   EXECR    | rs1 op rs2
//   EXECI    | rs1 op imm
//   ALUWB    | write ALUOut to rd, retire
//   JAL      | PC <= target, ALU forms link OldPC+4
//   BEQ      | compare, PC <= target when zero, retire
//   TRAP     | halted until reset
module multicycle_main_fsm
    import riscv_ctrl_pkg::*;
#(
    parameter bit          EN_IALU  = 1'b1,
    parameter bit          EN_JAL   = 1'b1,
    parameter int unsigned WAIT_MAX = 15,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       Op,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             MemWrite,
    output logic             AdrSrc,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             RegWrite,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       ImmSrc,
    output logic             retire,
    output logic [CNT_W-1:0] instret,
    output logic             trap,
    output logic [1:0]       trap_cause
);

    // Trap fires on the stall cycle that would bring the count to WAIT_MAX.
    localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

    state_e           state_q, state_d;
    logic [7:0]       wait_q, wait_d;
    logic [1:0]       cause_q, cause_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             mem_stall;

    imm_src_decode u_imm_src_decode (
        .op      (Op),
        .imm_src (ImmSrc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_FETCH;
            wait_q    <= 8'd0;
            cause_q   <= CAUSE_NONE;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            cause_q   <= cause_d;
            instret_q <= instret_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cause_d   = cause_q;
        mem_req   = 1'b0;
        MemWrite  = 1'b0;
        AdrSrc    = 1'b0;
        IRWrite   = 1'b0;
        PCWrite   = 1'b0;
        RegWrite  = 1'b0;
        ResultSrc = RES_ALUOUT;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_RS2;
        ALUOp     = ALUOP_ADD;
        retire    = 1'b0;
        trap      = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_req   = 1'b1;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                case (Op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = EN_IALU ? S_EXECI : S_TRAP;
                    OP_JAL:       state_d = EN_JAL ? S_JAL : S_TRAP;
                    OP_BEQ:       state_d = S_BEQ;
                    default:      state_d = S_TRAP;
                endcase
                if (state_d == S_TRAP) cause_d = CAUSE_ILLEGAL;
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                state_d = (Op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                AdrSrc  = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                RegWrite  = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req  = 1'b1;
                MemWrite = 1'b1;
                AdrSrc   = 1'b1;
                retire   = mem_ready;
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXECR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_RS2;
                ALUOp   = ALUOP_FUNCT;
                state_d = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                ALUOp   = ALUOP_FUNCT;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                ResultSrc = RES_ALUOUT;
                RegWrite  = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_JAL: begin
                ALUSrcA   = SRCA_OLDPC;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALUOUT;
                PCWrite   = 1'b1;
                state_d   = S_ALUWB;
            end
            S_BEQ: begin
                ALUSrcA   = SRCA_RS1;
                ALUSrcB   = SRCB_RS2;
                ALUOp     = ALUOP_SUB;
                ResultSrc = RES_ALUOUT;
                PCWrite   = zero;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_TRAP: begin
                trap = 1'b1;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        // A completing access (mem_ready=1) always wins over the timeout.
        mem_stall = mem_req && !mem_ready;
        if (mem_stall && (wait_q == WAIT_LAST)) begin
            state_d = S_TRAP;
            cause_d = CAUSE_TIMEOUT;
        end
        wait_d = (mem_stall && (state_d == state_q)) ? wait_q + 8'd1 : 8'd0;
    end

    assign instret_d  = instret_q + CNT_W'(retire);
    assign instret    = instret_q;
    assign trap_cause = cause_q;

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Randomized bench for multicycle_main_fsm: two configurations driven
// independently and compared each cycle against an instruction-level model.
module tb_multicycle_main_fsm;

    localparam bit EN_IALU_A = 1'b1, EN_JAL_A = 1'b1;
    localparam int WMAX_A = 15, CNTW_A = 32;
    localparam bit EN_IALU_B = 1'b0, EN_JAL_B = 1'b0;
    localparam int WMAX_B = 3, CNTW_B = 4;
    localparam int N_CYC = 6000;

    localparam int K_LW = 0, K_SW = 1, K_R = 2, K_I = 3, K_JAL = 4, K_BEQ = 5, K_ILL = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]      rst_v, zero_v, rdy_v;
    logic [1:0][6:0] op_v;
    logic [1:0]      mem_req_v, mw_v, adr_v, irw_v, pcw_v, rw_v, ret_v, trp_v;
    logic [1:0][1:0] res_v, sa_v, sb_v, aop_v, imm_v, tc_v;
    logic [31:0]     instret_a;
    logic [3:0]      instret_b;

    multicycle_main_fsm #(.EN_IALU(EN_IALU_A), .EN_JAL(EN_JAL_A), .WAIT_MAX(WMAX_A), .CNT_W(CNTW_A)) dut_a (
        .clk(clk), .rst(rst_v[0]), .Op(op_v[0]), .zero(zero_v[0]), .mem_ready(rdy_v[0]),
        .mem_req(mem_req_v[0]), .MemWrite(mw_v[0]), .AdrSrc(adr_v[0]), .IRWrite(irw_v[0]),
        .PCWrite(pcw_v[0]), .RegWrite(rw_v[0]), .ResultSrc(res_v[0]), .ALUSrcA(sa_v[0]),
        .ALUSrcB(sb_v[0]), .ALUOp(aop_v[0]), .ImmSrc(imm_v[0]), .retire(ret_v[0]),
        .instret(instret_a), .trap(trp_v[0]), .trap_cause(tc_v[0]));

    multicycle_main_fsm #(.EN_IALU(EN_IALU_B), .EN_JAL(EN_JAL_B), .WAIT_MAX(WMAX_B), .CNT_W(CNTW_B)) dut_b (
        .clk(clk), .rst(rst_v[1]), .Op(op_v[1]), .zero(zero_v[1]), .mem_ready(rdy_v[1]),
        .mem_req(mem_req_v[1]), .MemWrite(mw_v[1]), .AdrSrc(adr_v[1]), .IRWrite(irw_v[1]),
        .PCWrite(pcw_v[1]), .RegWrite(rw_v[1]), .ResultSrc(res_v[1]), .ALUSrcA(sa_v[1]),
        .ALUSrcB(sb_v[1]), .ALUOp(aop_v[1]), .ImmSrc(imm_v[1]), .retire(ret_v[1]),
        .instret(instret_b), .trap(trp_v[1]), .trap_cause(tc_v[1]));

    // Model: position within the current instruction, its class, stall count.
    int              ph[2], cls[2], wc[2], burst[2], trapcyc[2];
    bit              trp[2], in_rst[2];
    logic [1:0]      cause[2];
    longint unsigned cnt[2];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic int wmax(int d);
        return (d == 0) ? WMAX_A : WMAX_B;
    endfunction

    function automatic longint unsigned cnt_mask(int d);
        return (d == 0) ? 64'hFFFF_FFFF : 64'hF;
    endfunction

    function automatic int classify(int d, logic [6:0] op);
        case (op)
            7'b0000011: return K_LW;
            7'b0100011: return K_SW;
            7'b0110011: return K_R;
            7'b0010011: return ((d == 0) ? EN_IALU_A : EN_IALU_B) ? K_I : K_ILL;
            7'b1101111: return ((d == 0) ? EN_JAL_A : EN_JAL_B) ? K_JAL : K_ILL;
            7'b1100011: return K_BEQ;
            default:    return K_ILL;
        endcase
    endfunction

    function automatic int inst_len(int k);
        case (k)
            K_LW:    return 5;
            K_BEQ:   return 3;
            default: return 4;
        endcase
    endfunction

    function automatic logic [1:0] imm_of(logic [6:0] op);
        case (op)
            7'b0100011: return 2'b01;
            7'b1100011: return 2'b10;
            7'b1101111: return 2'b11;
            default:    return 2'b00;
        endcase
    endfunction

    function automatic bit mem_phase(int d);
        return (ph[d] == 0) || (ph[d] == 3 && (cls[d] == K_LW || cls[d] == K_SW));
    endfunction

    function automatic logic [19:0] expect_outs(int d);
        logic mreq, mw, adr, irw, pcw, rw, ret, tp;
        logic [1:0] res, sa, sb, aop;
        logic mr, z;
        mr = rdy_v[d];
        z  = zero_v[d];
        {mreq, mw, adr, irw, pcw, rw, ret, tp} = '0;
        {res, sa, sb, aop} = '0;
        if (trp[d]) tp = 1'b1;
        else if (ph[d] == 0) begin
            mreq = 1'b1; sb = 2'b10; res = 2'b10; irw = mr; pcw = mr;
        end else if (ph[d] == 1) begin
            sa = 2'b01; sb = 2'b01;
        end else if (ph[d] == inst_len(cls[d]) - 1 && (cls[d] == K_R || cls[d] == K_I || cls[d] == K_JAL)) begin
            rw = 1'b1; ret = 1'b1;
        end else begin
            case (cls[d])
                K_LW, K_SW: begin
                    if (ph[d] == 2) begin sa = 2'b10; sb = 2'b01; end
                    else if (ph[d] == 3) begin
                        mreq = 1'b1; adr = 1'b1;
                        if (cls[d] == K_SW) begin mw = 1'b1; ret = mr; end
                    end else begin res = 2'b01; rw = 1'b1; ret = 1'b1; end
                end
                K_R:   begin sa = 2'b10; sb = 2'b00; aop = 2'b10; end
                K_I:   begin sa = 2'b10; sb = 2'b01; aop = 2'b10; end
                K_JAL: begin sa = 2'b01; sb = 2'b10; pcw = 1'b1; end
                K_BEQ: begin sa = 2'b10; aop = 2'b01; pcw = z; ret = 1'b1; end
                default: ;
            endcase
        end
        return {mreq, mw, adr, irw, pcw, rw, res, sa, sb, aop, imm_of(op_v[d]), ret, tp, cause[d]};
    endfunction

    function automatic logic [19:0] dut_outs(int d);
        return {mem_req_v[d], mw_v[d], adr_v[d], irw_v[d], pcw_v[d], rw_v[d], res_v[d], sa_v[d],
                sb_v[d], aop_v[d], imm_v[d], ret_v[d], trp_v[d], tc_v[d]};
    endfunction

    task automatic advance(int d);
        if (ph[d] == 1) begin
            cls[d] = classify(d, op_v[d]);
            if (cls[d] == K_ILL) begin trp[d] = 1'b1; cause[d] = 2'b01; return; end
        end
        ph[d]++;
        wc[d] = 0;
        if (ph[d] == inst_len(cls[d])) begin ph[d] = 0; cnt[d]++; end
    endtask

    task automatic model_step(int d);
        if (in_rst[d]) return;
        if (trp[d]) begin trapcyc[d]++; return; end
        if (mem_phase(d)) begin
            if (rdy_v[d]) advance(d);
            else if (wc[d] + 1 == wmax(d)) begin trp[d] = 1'b1; cause[d] = 2'b10; wc[d] = 0; end
            else wc[d]++;
        end else advance(d);
    endtask

    task automatic model_reset(int d);
        ph[d] = 0; cls[d] = K_LW; wc[d] = 0; trp[d] = 1'b0; cause[d] = 2'b00;
        cnt[d] = 0; trapcyc[d] = 0; burst[d] = 0; in_rst[d] = 1'b1;
    endtask

    function automatic logic [6:0] pick_op(int d);
        logic [6:0] ops [6];
        int r;
        ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b1100011, 7'b0010011, 7'b1101111};
        r = $urandom_range(0, 99);
        if (r < ((d == 0) ? 8 : 2)) return 7'($urandom_range(0, 127));
        if (d == 1 && r < 4) return ops[$urandom_range(4, 5)];
        return ops[$urandom_range(0, (d == 0) ? 5 : 3)];
    endfunction

    task automatic drive(int d);
        if (in_rst[d]) begin
            rst_v[d] = 1'b1;
            in_rst[d] = 1'b0;
        end else if ((trp[d] && trapcyc[d] >= 3) || $urandom_range(0, 399) == 0) begin
            rst_v[d] = 1'b0;
            model_reset(d);
        end
        if (ph[d] == 0 || trp[d]) op_v[d] = pick_op(d);
        zero_v[d] = 1'($urandom_range(0, 1));
        if (burst[d] > 0) begin
            rdy_v[d] = 1'b0;
            burst[d]--;
        end else if ($urandom_range(0, (d == 0) ? 9 : 39) == 0) begin
            // Low runs of WAIT_MAX-1 or WAIT_MAX cycles hit both sides of the timeout.
            burst[d] = $urandom_range(wmax(d) - 1, wmax(d)) - 1;
            rdy_v[d] = 1'b0;
        end else begin
            rdy_v[d] = ($urandom_range(0, 4) != 0);
        end
    endtask

    initial begin
        rst_v  = 2'b00;
        zero_v = 2'b00;
        rdy_v  = 2'b11;
        op_v   = '0;
        for (int d = 0; d < 2; d++) model_reset(d);
        for (int cyc = 0; cyc < N_CYC; cyc++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                check($sformatf("dut%0d.outs t=%0t", d, $time), 32'(dut_outs(d)), 32'(expect_outs(d)));
                check($sformatf("dut%0d.instret t=%0t", d, $time),
                      (d == 0) ? instret_a : {28'd0, instret_b}, 32'(cnt[d] & cnt_mask(d)));
                model_step(d);
            end
            @(posedge clk);
            #1;
            for (int d = 0; d < 2; d++) drive(d);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
